// File: rtl/pmc_shift_sequencer.sv
// Pixel-matrix shift sequencer: generates clk_sh pulses, drives pm_din and
// captures one pm_dout word per pulse into a small first-word-fall-through FIFO.
module pmc_shift_sequencer #(
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [CNT_W-1:0]              shift_count,
  input  logic [DIV_W-1:0]              clk_high,
  input  logic [DIV_W-1:0]              clk_low,
  input  logic [63:0]                   din_word,
  input  logic [63:0]                   pm_dout,
  input  logic                          fifo_rd,
  input  logic                          fifo_clr,
  output logic [63:0]                   pm_din,
  output logic                          clk_sh,
  output logic                          busy,
  output logic                          done,
  output logic [63:0]                   fifo_rdata,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_STALL
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [DIV_W-1:0] r_high;
  logic [DIV_W-1:0] r_low;
  logic [DIV_W-1:0] r_phase;

  logic [63:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;

  logic             w_push;
  logic             w_pop;
  logic [LW-1:0]    w_level_nxt;

  // Capture happens on the last high cycle; an abort in that cycle drops it.
  assign w_push = (r_state == S_HIGH) && (r_phase == '0) && !abort;
  assign w_pop  = fifo_rd && (fifo_level != '0);

  always_comb begin
    w_level_nxt = fifo_level;
    if (fifo_clr) begin
      w_level_nxt = '0;
    end else begin
      w_level_nxt = fifo_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // Sequencer FSM; full checks use the registered flag, so a same-cycle pop does not unblock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_high      <= '0;
      r_low       <= '0;
      r_phase     <= '0;
      pm_din      <= '0;
      clk_sh      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        clk_sh  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (shift_count != '0) begin
                r_state     <= S_SETUP;
                busy        <= 1'b1;
                r_remaining <= shift_count;
                r_high      <= clk_high;
                r_low       <= clk_low;
                pm_din      <= din_word;
              end else begin
                done <= 1'b1;
              end
            end
          end
          S_SETUP: begin
            if (!fifo_full) begin
              r_state <= S_HIGH;
              clk_sh  <= 1'b1;
              r_phase <= r_high;
            end else begin
              r_state <= S_STALL;
            end
          end
          S_HIGH: begin
            if (r_phase == '0) begin
              r_state     <= S_LOW;
              clk_sh      <= 1'b0;
              r_phase     <= r_low;
              r_remaining <= r_remaining - CNT_W'(1);
            end else begin
              r_phase <= r_phase - DIV_W'(1);
            end
          end
          S_LOW: begin
            if (r_phase == '0) begin
              if (r_remaining == '0) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else if (fifo_full) begin
                r_state <= S_STALL;
              end else begin
                r_state <= S_HIGH;
                clk_sh  <= 1'b1;
                r_phase <= r_high;
              end
            end else begin
              r_phase <= r_phase - DIV_W'(1);
            end
          end
          S_STALL: begin
            if (!fifo_full) begin
              r_state <= S_HIGH;
              clk_sh  <= 1'b1;
              r_phase <= r_high;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !fifo_clr) begin
      r_mem[r_wptr] <= pm_dout;
    end
  end

  // FIFO control; fifo_rdata is kept equal to the head so reads see it with no latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      fifo_level <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      fifo_rdata <= '0;
    end else begin
      if (fifo_clr) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        if (w_pop && (fifo_level > LW'(1))) begin
          fifo_rdata <= r_mem[r_rptr + AW'(1)];
        end else if (w_push && ((fifo_level == '0) || w_pop)) begin
          fifo_rdata <= pm_dout;
        end
      end
      fifo_level <= w_level_nxt;
      fifo_empty <= (w_level_nxt == '0);
      fifo_full  <= (w_level_nxt == LW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_pmc_shift_sequencer.sv
// Directed bench for pmc_shift_sequencer: cycle-indexed waveform checks plus a
// scoreboard of expected captured words drained through the FIFO head.
module tb_pmc_shift_sequencer;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             fifo_rd = 1'b0;
  logic             fifo_clr = 1'b0;
  logic [CNT_W-1:0] shift_count = '0;
  logic [DIV_W-1:0] clk_high = '0;
  logic [DIV_W-1:0] clk_low = '0;
  logic [63:0]      din_word = '0;
  logic [63:0]      pm_dout;
  logic [63:0]      pm_din;
  logic [63:0]      fifo_rdata;
  logic             clk_sh;
  logic             busy;
  logic             done;
  logic             fifo_empty;
  logic             fifo_full;
  logic [LW-1:0]    fifo_level;

  int          cyc = 0;
  int          n_asrt = 0;
  int          n_fail = 0;
  int          ncyc = 0;
  int          c0 = 0;
  logic [255:0] sh_log;
  logic [255:0] done_log;
  logic [255:0] busy_log;
  logic [63:0] q[$];

  function automatic logic [63:0] word_at(input int c);
    return {32'hDA7A_0000 ^ 32'(c), ~32'(c)};
  endfunction

  assign pm_dout = word_at(cyc);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pmc_shift_sequencer #(.CNT_W(CNT_W), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .shift_count(shift_count),
    .clk_high   (clk_high),
    .clk_low    (clk_low),
    .din_word   (din_word),
    .pm_dout    (pm_dout),
    .fifo_rd    (fifo_rd),
    .fifo_clr   (fifo_clr),
    .pm_din     (pm_din),
    .clk_sh     (clk_sh),
    .busy       (busy),
    .done       (done),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_level (fifo_level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    logic [63:0] e;
    n_asrt++;
    assert (q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: observed head %h expected no data", tag, fifo_rdata);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(tag, fifo_rdata, e);
    end
  endtask

  // Log this cycle's outputs, optionally pop the head, then advance one cycle.
  task automatic step(input bit drain);
    sh_log[ncyc]   = clk_sh;
    done_log[ncyc] = done;
    busy_log[ncyc] = busy;
    if (drain && !fifo_empty) begin
      pop_cmp("drain_pop");
      fifo_rd = 1'b1;
    end
    @(posedge clk);
    #1;
    fifo_rd = 1'b0;
    ncyc++;
  endtask

  task automatic do_start(input int cnt, input int hi, input int lo, input logic [63:0] din);
    shift_count = CNT_W'(cnt);
    clk_high    = DIV_W'(hi);
    clk_low     = DIV_W'(lo);
    din_word    = din;
    start       = 1'b1;
    sh_log      = '0;
    done_log    = '0;
    busy_log    = '0;
    ncyc        = 0;
    c0          = cyc;
    step(1'b0);
    start = 1'b0;
  endtask

  task automatic push_exp(input int cnt, input int hi, input int lo);
    for (int k = 0; k < cnt; k++) q.push_back(word_at(c0 + 2 + hi + k * (hi + lo + 2)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pm_din", pm_din, 64'h0);
    chk("rst_clk_sh", 64'(clk_sh), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_empty", 64'(fifo_empty), 64'h1);
    chk("rst_full", 64'(fifo_full), 64'h0);
    chk("rst_level", 64'(fifo_level), 64'h0);
    chk("rst_rdata", fifo_rdata, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3 pulses, 1 high + 2 low, drained continuously
    do_start(3, 0, 1, 64'h1111_2222_3333_4444);
    push_exp(3, 0, 1);
    repeat (11) step(1'b1);
    chk("t1_clk_sh_wave", 64'(sh_log[11:0]), 64'h124);
    chk("t1_done_wave", 64'(done_log[11:0]), 64'h800);
    chk("t1_busy_wave", 64'(busy_log[11:0]), 64'h7FE);
    chk("t1_sb_empty", 64'(q.size()), 64'h0);
    chk("t1_fifo_empty", 64'(fifo_empty), 64'h1);
    chk("t1_pm_din", pm_din, 64'h1111_2222_3333_4444);

    // 6 pulses into a 4-deep FIFO with no reads: stall, single pop, then drain
    do_start(6, 1, 0, 64'h2222_0000_0000_0002);
    push_exp(4, 1, 0);
    repeat (19) step(1'b0);
    chk("t2_clk_sh_wave", 64'(sh_log[19:0]), 64'h1B6C);
    chk("t2_busy_wave", 64'(busy_log[19:0]), 64'hFFFFE);
    chk("t2_stall_clk_sh", 64'(clk_sh), 64'h0);
    chk("t2_stall_busy", 64'(busy), 64'h1);
    chk("t2_stall_full", 64'(fifo_full), 64'h1);
    chk("t2_stall_level", 64'(fifo_level), 64'h4);
    q.push_back(word_at(cyc + 3));
    step(1'b1);
    repeat (11) step(1'b0);
    chk("t2_one_more_pulse", 64'(sh_log[31:20]), 64'h00C);
    chk("t2_restall_full", 64'(fifo_full), 64'h1);
    chk("t2_restall_busy", 64'(busy), 64'h1);
    q.push_back(word_at(cyc + 3));
    repeat (8) step(1'b1);
    chk("t2_last_pulse", 64'(sh_log[39:32]), 64'h0C);
    chk("t2_done_wave", 64'(done_log[39:0]), 64'h20_0000_0000);
    chk("t2_busy_end", 64'(busy), 64'h0);
    chk("t2_sb_empty", 64'(q.size()), 64'h0);
    chk("t2_fifo_empty", 64'(fifo_empty), 64'h1);

    // abort in the first cycle of the second high phase
    do_start(5, 3, 0, 64'h3333_0000_0000_0003);
    q.push_back(word_at(c0 + 5));
    repeat (6) step(1'b0);
    chk("t3_in_high2", 64'(clk_sh), 64'h1);
    abort = 1'b1;
    step(1'b0);
    abort = 1'b0;
    chk("t3_abort_clk_sh", 64'(clk_sh), 64'h0);
    chk("t3_abort_busy", 64'(busy), 64'h0);
    chk("t3_abort_level", 64'(fifo_level), 64'h1);
    repeat (5) step(1'b0);
    chk("t3_no_done", 64'(done_log[12:0]), 64'h0);
    chk("t3_clk_sh_low", 64'(sh_log[12:8]), 64'h0);
    step(1'b1);
    chk("t3_pm_din_hold", pm_din, 64'h3333_0000_0000_0003);
    chk("t3_fifo_empty", 64'(fifo_empty), 64'h1);

    // zero shift count completes immediately
    do_start(0, 2, 2, 64'h4444_0000_0000_0004);
    chk("t4_done", 64'(done), 64'h1);
    chk("t4_busy", 64'(busy), 64'h0);
    step(1'b0);
    chk("t4_done_once", 64'(done), 64'h0);
    repeat (3) step(1'b0);
    chk("t4_clk_sh_wave", 64'(sh_log[4:0]), 64'h0);
    chk("t4_level", 64'(fifo_level), 64'h0);

    // start while busy with different config is ignored
    do_start(2, 0, 0, 64'h5555_0000_0000_0005);
    push_exp(2, 0, 0);
    step(1'b1);
    step(1'b1);
    shift_count = CNT_W'(9);
    clk_high    = DIV_W'(5);
    clk_low     = DIV_W'(5);
    din_word    = 64'h5555_FFFF_FFFF_FFFF;
    start       = 1'b1;
    step(1'b1);
    start = 1'b0;
    repeat (6) step(1'b1);
    chk("t5_clk_sh_wave", 64'(sh_log[9:0]), 64'h014);
    chk("t5_done_wave", 64'(done_log[9:0]), 64'h040);
    chk("t5_pm_din", pm_din, 64'h5555_0000_0000_0005);
    chk("t5_sb_empty", 64'(q.size()), 64'h0);

    // push together with pop at level 2
    do_start(3, 0, 3, 64'h6666_0000_0000_0006);
    push_exp(3, 0, 3);
    repeat (11) step(1'b0);
    chk("t6_level_before", 64'(fifo_level), 64'h2);
    step(1'b1);
    chk("t6_level_push_pop", 64'(fifo_level), 64'h2);
    repeat (5) step(1'b0);
    chk("t6_done_wave", 64'(done_log[18:0]), 64'h20000);

    // clear together with a push
    do_start(2, 0, 0, 64'h6666_0000_0000_0007);
    step(1'b0);
    fifo_clr = 1'b1;
    step(1'b0);
    fifo_clr = 1'b0;
    chk("t6_clr_level", 64'(fifo_level), 64'h0);
    chk("t6_clr_empty", 64'(fifo_empty), 64'h1);
    q.delete();
    q.push_back(word_at(c0 + 4));
    step(1'b0);
    step(1'b0);
    chk("t6_after_clr_level", 64'(fifo_level), 64'h1);
    step(1'b1);
    chk("t6_sb_empty", 64'(q.size()), 64'h0);

    // asynchronous reset mid-high
    do_start(4, 3, 0, 64'h7777_0000_0000_0007);
    step(1'b0);
    step(1'b0);
    chk("t7_in_high", 64'(clk_sh), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_clk_sh", 64'(clk_sh), 64'h0);
    chk("t7_rst_busy", 64'(busy), 64'h0);
    chk("t7_rst_empty", 64'(fifo_empty), 64'h1);
    chk("t7_rst_level", 64'(fifo_level), 64'h0);
    chk("t7_rst_pm_din", pm_din, 64'h0);
    chk("t7_rst_rdata", fifo_rdata, 64'h0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(1'b0);
    chk("t7_post_clk_sh", 64'(clk_sh), 64'h0);
    chk("t7_post_busy", 64'(busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/pmc_shift_sequencer.md
Name: pmc_shift_sequencer

Overview:
- Hardware sequencer that drives the pixel-matrix shift clock (clk_sh) and the matrix data input (pm_din).
- Captures one 64-bit pm_dout word per shift pulse into a small first-word-fall-through (FWFT) FIFO, which software or the PMC coprocessor drains.
- Offloads tight readout loops from the PMC coprocessor; sits beside the PMC register block, which supplies configuration and pops the FIFO.

Parameters:
- CNT_W, 10, width of shift_count and the remaining-shift counter.
- DIV_W, 8, width of the clk_high / clk_low phase-length fields.
- FIFO_DEPTH, 4, number of 64-bit capture entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; already decided.
- rst_n  in  1  asynchronous, active-low reset; already decided.
- start  in  1  single-cycle request to begin a sequence.
- abort  in  1  single-cycle request to terminate the current sequence.
- shift_count  in  CNT_W  number of clk_sh pulses to generate.
- clk_high  in  DIV_W  clk_sh high phase length is clk_high+1 cycles.
- clk_low  in  DIV_W  clk_sh low phase length is clk_low+1 cycles.
- din_word  in  64  value driven on pm_din for the whole sequence.
- pm_dout  in  64  matrix data output.
- fifo_rd  in  1  pop the FIFO head.
- fifo_clr  in  1  flush the FIFO.
- pm_din  out  64  registered matrix data input.
- clk_sh  out  1  registered shift clock.
- busy  out  1  high while not in IDLE.
- done  out  1  one-cycle pulse when a sequence completes normally.
- fifo_rdata  out  64  FIFO head (FWFT).
- fifo_empty  out  1  FIFO empty flag.
- fifo_full  out  1  FIFO full flag.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: pm_din=0, clk_sh=0, busy=0, done=0, FIFO empty, fifo_rdata=0, fifo_level=0, state IDLE.
- All outputs are registered.
- States: IDLE, SETUP, HIGH, LOW, STALL.
- IDLE:
  - start && shift_count!=0 -> SETUP.
  - Same cycle: latch shift_count, clk_high, clk_low; pm_din<=din_word.
  - start && shift_count==0 -> stay in IDLE; done=1 next cycle; no clk_sh activity.
- SETUP: one cycle.
  - -> HIGH if !fifo_full, else -> STALL.
- Timing: with start sampled at cycle 0, clk_sh is first high at cycle 2.
- HIGH:
  - clk_sh=1 for clk_high+1 cycles; the phase counter reloads on each entry.
  - Last HIGH cycle: push pm_dout into the FIFO; decrement remaining; -> LOW.
- LOW: clk_sh=0 for clk_low+1 cycles. At the last LOW cycle:
  - remaining==0 -> IDLE, with done=1 in the following cycle.
  - else fifo_full -> STALL.
  - else -> HIGH.
- STALL: clk_sh=0; -> HIGH on the first cycle with !fifo_full.
- Full check uses fifo_full as registered that cycle; a concurrent fifo_rd does not unblock in the same cycle.
- Period without stalls: (clk_high+1)+(clk_low+1) cycles. Every clk_sh pulse is complete; a high phase is never truncated except by abort.
- start while busy: ignored.
- Config inputs are ignored after latching.
- abort, any non-IDLE state:
  - -> IDLE next cycle; clk_sh=0 next cycle; no done pulse.
  - pm_din holds; FIFO contents retained.
  - abort has priority over start and over all transitions.
- FIFO:
  - Push and pop in the same cycle are both honored; level unchanged.
  - Pop when empty is ignored; fifo_rdata holds its last value.
  - Push never happens when full, by construction.
  - fifo_clr empties the FIFO next cycle and has priority over push/pop.
  - fifo_clr while busy is legal; the sequence continues.
- Pointers wrap modulo FIFO_DEPTH.
- rst_n assertion mid-sequence forces reset values immediately.

Test Plan:
- shift_count=3, clk_high=0, clk_low=1, FIFO drained continuously -> 3 pulses, each 1 cycle high then 2 cycles low; first high at start+2; 3 words captured equal to pm_dout in each last-high cycle; done pulses once, 1 cycle after the final LOW.
- shift_count=6, FIFO_DEPTH=4, no fifo_rd -> 4 pulses then STALL with clk_sh=0 and busy=1. Pop one entry -> exactly one more pulse. Pop all -> remaining pulses, then done.
- abort during the 2nd HIGH of shift_count=5, clk_high=3 -> clk_sh=0 the next cycle; busy=0; no done; FIFO holds 1 word.
- shift_count=0 with start -> done next cycle; clk_sh never rises; FIFO unchanged.
- start asserted while busy, with different config -> ignored; original count and timing complete unchanged.
- Simultaneous push and fifo_rd at level 2 -> level stays 2. fifo_clr together with a push -> level 0 next cycle. rst_n pulse mid-HIGH -> clk_sh=0, busy=0, FIFO empty, pm_din=0.
